// File: rtl/kbd_scan_ctrl.sv
// kbd_scan_ctrl: PS/2 keyboard receiver with make/break tracking and a key-press counter for hex displays.
// Define PARITY_CHK_EN to reject frames whose data+parity bits do not have odd parity.
module kbd_scan_ctrl #(
   parameter int TIMEOUT_CYC = 5000,
   parameter int SYNC_STAGES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [3:0] code_hi,
   output logic [3:0] code_lo,
   output logic [3:0] cnt_hi,
   output logic [3:0] cnt_lo,
   output logic       key_valid,
   output logic       byte_stb,
   output logic       frame_err
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t state, state_nx;
   logic [SYNC_STAGES-1:0] clk_sync, data_sync;
   logic clk_prev, bit_evt, bit_val, par_ok, tmo_hit;
   logic [7:0] shift, shift_nx, held, cnt;
   logic [2:0] bit_idx, bit_idx_nx;
   logic par, par_nx, stb_nx, err_nx, break_pend, ext_pend, unused;
   logic [TW-1:0] tmo;
   assign bit_evt = clk_prev & ~clk_sync[SYNC_STAGES-1];
   assign bit_val = data_sync[SYNC_STAGES-1];
   assign tmo_hit = (state != IDLE) && (tmo == TW'(TIMEOUT_CYC - 1));
`ifdef PARITY_CHK_EN
   assign par_ok = ^{shift, par};
`else
   assign par_ok = 1'b1;
`endif
   // The E0 prefix only influences flag clearing, so nothing downstream reads it.
   assign unused = ext_pend;
   assign code_hi = key_valid ? held[7:4] : 4'hF;
   assign code_lo = key_valid ? held[3:0] : 4'hF;
   assign cnt_hi = cnt[7:4];
   assign cnt_lo = cnt[3:0];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
         clk_prev  <= clk_sync[SYNC_STAGES-1];
      end
   end
   // Saturating idle-time counter; a frame is abandoned when it hits the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tmo <= '0;
      else if (bit_evt)
         tmo <= '0;
      else if (tmo != TW'(TIMEOUT_CYC - 1))
         tmo <= tmo + TW'(1);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         shift     <= '0;
         bit_idx   <= '0;
         par       <= 1'b0;
         byte_stb  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nx;
         shift     <= shift_nx;
         bit_idx   <= bit_idx_nx;
         par       <= par_nx;
         byte_stb  <= stb_nx;
         frame_err <= err_nx;
      end
   end
   always_comb begin
      state_nx   = state;
      shift_nx   = shift;
      bit_idx_nx = bit_idx;
      par_nx     = par;
      stb_nx     = 1'b0;
      err_nx     = 1'b0;
      if (bit_evt) begin
         case (state)
            IDLE: begin
               state_nx   = bit_val ? IDLE : DATA;
               bit_idx_nx = '0;
            end
            DATA: begin
               shift_nx   = {bit_val, shift[7:1]};
               bit_idx_nx = bit_idx + 3'd1;
               state_nx   = (bit_idx == 3'd7) ? PARITY : DATA;
            end
            PARITY: begin
               par_nx   = bit_val;
               state_nx = STOP;
            end
            STOP: begin
               stb_nx   = bit_val & par_ok;
               err_nx   = ~(bit_val & par_ok);
               state_nx = IDLE;
            end
         endcase
      end else if (tmo_hit) begin
         err_nx   = 1'b1;
         state_nx = IDLE;
      end
   end
   // shift still holds the received byte while byte_stb is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held       <= 8'hFF;
         cnt        <= '0;
         key_valid  <= 1'b0;
         break_pend <= 1'b0;
         ext_pend   <= 1'b0;
      end else if (byte_stb) begin
         if (shift == 8'hE0)
            ext_pend <= 1'b1;
         else if (shift == 8'hF0)
            break_pend <= 1'b1;
         else if (break_pend) begin
            if (key_valid && shift == held)
               key_valid <= 1'b0;
            break_pend <= 1'b0;
            ext_pend   <= 1'b0;
         end else if (!(key_valid && shift == held)) begin
            held      <= shift;
            key_valid <= 1'b1;
            cnt       <= cnt + 8'd1;
            ext_pend  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// tb_kbd_scan_ctrl: random and directed PS/2 frames checked against a byte-level keyboard model.
module tb_kbd_scan_ctrl;
   localparam int T = 5000;
   localparam int S = 3;
   localparam int H = 4;
   logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic [3:0] code_hi, code_lo, cnt_hi, cnt_lo;
   logic key_valid, byte_stb, frame_err;
   logic [7:0] c_pre, c_post;
   int vectors = 0, errors = 0, stb_n = 0, err_n = 0, both_n = 0;
   int m_held = -1, m_cnt = 0, m_stb = 0, m_err = 0;
   bit m_brk = 1'b0;
   int pool [4] = '{'h1C, 'h32, 'h75, 'h5A};

   kbd_scan_ctrl #(.TIMEOUT_CYC(T), .SYNC_STAGES(S)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .code_hi(code_hi), .code_lo(code_lo), .cnt_hi(cnt_hi), .cnt_lo(cnt_lo),
      .key_valid(key_valid), .byte_stb(byte_stb), .frame_err(frame_err));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      stb_n += int'(byte_stb);
      err_n += int'(frame_err);
      if (byte_stb && frame_err) both_n++;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_code();
      return (m_held < 0) ? 8'hFF : m_held[7:0];
   endfunction

   function automatic void model(input int b);
      if (b == 'hF0) m_brk = 1'b1;
      else if (b != 'hE0) begin
         if (m_brk) begin
            if (b == m_held) m_held = -1;
            m_brk = 1'b0;
         end else if (b != m_held) begin
            m_held = b;
            m_cnt = (m_cnt + 1) % 256;
         end
      end
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, "_code"}, {code_hi, code_lo}, exp_code());
      check({tag, "_kv"}, key_valid, m_held >= 0);
      check({tag, "_cnt"}, {cnt_hi, cnt_lo}, m_cnt);
      check({tag, "_nstb"}, stb_n, m_stb);
      check({tag, "_nerr"}, err_n, m_err);
   endtask

   task automatic check_rst(input string tag);
      check({tag, "_code"}, {code_hi, code_lo}, 8'hFF);
      check({tag, "_kv"}, key_valid, 0);
      check({tag, "_cnt"}, {cnt_hi, cnt_lo}, 0);
      check({tag, "_stb"}, byte_stb, 0);
      check({tag, "_ferr"}, frame_err, 0);
   endtask

   task automatic edge_wait(input int lim, output int lat);
      lat = -1;
      for (int i = 1; i <= lim; i++) begin
         @(negedge clk);
         if (i == H) ps2_clk = 1'b1;
         if (lat > 0 && i == lat + 1) c_post = {code_hi, code_lo};
         if (lat < 0 && (byte_stb || frame_err)) begin
            lat = i;
            c_pre = {code_hi, code_lo};
         end
      end
   endtask

   task automatic bit_out(input bit v, input int lim, output int lat);
      ps2_data = v;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      edge_wait(lim, lat);
   endtask

   task automatic send_frame(input int b, input bit bad, input bit lat_chk);
      int lat;
      bit ok;
      logic [7:0] bv, pre;
      bv = b[7:0];
      ok = !bad;
`ifndef PARITY_CHK_EN
      ok = 1'b1;
`endif
      pre = exp_code();
      bit_out(1'b0, H, lat);
      for (int i = 0; i < 8; i++) bit_out(bv[i], H, lat);
      bit_out(~^bv ^ bad, H, lat);
      bit_out(1'b1, 12, lat);
      ps2_data = 1'b1;
      if (ok) begin
         m_stb++;
         model(b);
      end else m_err++;
      if (lat_chk) begin
         check("stb_latency", lat, S + 1);
         check("code_before", c_pre, pre);
         check("code_after", c_post, exp_code());
      end
      repeat (4) @(negedge clk);
      check_outputs($sformatf("frame_%02h", bv));
   endtask

   initial begin
      int lat;
      repeat (4) @(negedge clk);
      check_rst("reset");
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check_rst("post_reset");
      // make, gap, break
      send_frame('h1C, 1'b0, 1'b1);
      repeat (200) @(negedge clk);
      send_frame('hF0, 1'b0, 1'b0);
      send_frame('h1C, 1'b0, 1'b1);
      // typematic repeats
      repeat (5) send_frame('h1C, 1'b0, 1'b0);
      send_frame('hF0, 1'b0, 1'b0);
      send_frame('h1C, 1'b0, 1'b0);
      // wrong parity
      send_frame('h1C, 1'b1, 1'b0);
      send_frame('hF0, 1'b0, 1'b0);
      send_frame('h1C, 1'b0, 1'b0);
      // ps2_clk stops after 4 data bits
      bit_out(1'b0, H, lat);
      for (int i = 0; i < 3; i++) bit_out(1'b1, H, lat);
      bit_out(1'b0, T + S + 20, lat);
      ps2_data = 1'b1;
      m_err++;
      check("timeout_latency", lat, T + S + 1);
      check_outputs("timeout");
      send_frame('h32, 1'b0, 1'b0);
      // counter wrap over 256 new makes
      for (int i = 0; i < 256; i++) send_frame((i % 2) ? 'h32 : 'h1C, 1'b0, 1'b0);
      send_frame('h1C, 1'b0, 1'b0);
      send_frame('h32, 1'b0, 1'b1);
      // random traffic
      for (int n = 0; n < 230; n++) begin
         int r, b;
         r = $urandom_range(15);
         b = (r == 0) ? 'hE0 : (r < 4) ? 'hF0 : (r == 4) ? $urandom_range(255) : pool[$urandom_range(3)];
         send_frame(b, $urandom_range(11) == 0, 1'b0);
      end
      // reset in the middle of a frame
      bit_out(1'b0, H, lat);
      for (int i = 0; i < 5; i++) bit_out(1'b1, H, lat);
      ps2_data = 1'b0;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      check_rst("mid_reset");
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      repeat (S + 2) @(negedge clk);
      rst = 1'b0;
      m_held = -1;
      m_cnt = 0;
      m_brk = 1'b0;
      repeat (2) @(negedge clk);
      check_rst("mid_release");
      send_frame('hE0, 1'b0, 1'b0);
      send_frame('hF0, 1'b0, 1'b0);
      send_frame('h75, 1'b0, 1'b0);
      send_frame('h75, 1'b0, 1'b1);
      check("stb_err_overlap", both_n, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
